// File: rtl/booth_pkg.sv
// ----------------------------------------------------------------------------
// booth_pkg
// Shared definitions for the sequential radix-4 Booth multiplier.
//   - state_e        : controller states (IDLE, RUN, DONE)
//   - WIN_*          : 3-bit multiplier window codes scanned each step
//   - booth_steps()  : number of Booth steps for a given operand width
// Optional macro: BOOTH_SIGNED_EN (two's-complement operands, one fewer step).
// ----------------------------------------------------------------------------
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Window codes {b[2i+1], b[2i], b[2i-1]} and the digit each one selects.
    localparam logic [2:0] WIN_ZERO_LO = 3'b000;  //  0
    localparam logic [2:0] WIN_POS1_A  = 3'b001;  // +A
    localparam logic [2:0] WIN_POS1_B  = 3'b010;  // +A
    localparam logic [2:0] WIN_POS2    = 3'b011;  // +2A
    localparam logic [2:0] WIN_NEG2    = 3'b100;  // -2A
    localparam logic [2:0] WIN_NEG1_A  = 3'b101;  // -A
    localparam logic [2:0] WIN_NEG1_B  = 3'b110;  // -A
    localparam logic [2:0] WIN_ZERO_HI = 3'b111;  //  0

    // Unsigned operands need one extra step so the zero-padded top window
    // can absorb a set MSB of the multiplier.
    function automatic int booth_steps(input int width);
`ifdef BOOTH_SIGNED_EN
        return width / 2;
`else
        return width / 2 + 1;
`endif
    endfunction

endpackage

// File: rtl/booth_mult_seq_if.sv
// ----------------------------------------------------------------------------
// booth_mult_seq_if
// Start/ready/done handshake bundle for booth_mult_seq.
//   start   : request a multiply (sampled only while ready=1)
//   a, b    : multiplicand / multiplier, WIDTH bits each
//   ready   : multiplier idle and able to accept start
//   done    : one-cycle pulse, product valid
//   product : 2*WIDTH-bit result
// Modports: master (requester), slave (multiplier).
// ----------------------------------------------------------------------------
interface booth_mult_seq_if #(
    parameter int WIDTH = 4
);
    logic                   start;
    logic [WIDTH-1:0]       a;
    logic [WIDTH-1:0]       b;
    logic                   ready;
    logic                   done;
    logic [2*WIDTH-1:0]     product;

    modport master (
        output start, a, b,
        input  ready, done, product
    );

    modport slave (
        input  start, a, b,
        output ready, done, product
    );
endinterface

// File: rtl/booth_pp_gen.sv
// ----------------------------------------------------------------------------
// booth_pp_gen
// Combinational radix-4 Booth partial-product generator.
//   window    : 3-bit overlapping multiplier window
//   mcand_ext : multiplicand extended to 2*WIDTH+2 bits
//   step      : step index; the partial product is shifted left by 2*step
//   pp        : shifted partial product, 2*WIDTH+2 bits (modulo arithmetic)
// ----------------------------------------------------------------------------
module booth_pp_gen
    import booth_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int STEP_W = 2
) (
    input  logic [2:0]            window,
    input  logic [2*WIDTH+1:0]    mcand_ext,
    input  logic [STEP_W-1:0]     step,
    output logic [2*WIDTH+1:0]    pp
);
    localparam int XW = 2 * WIDTH + 2;

    logic [XW-1:0] mag;

    always_comb begin
        mag = '0;
        case (window)
            WIN_POS1_A, WIN_POS1_B: mag = mcand_ext;
            WIN_POS2:               mag = mcand_ext << 1;
            WIN_NEG2:               mag = -(mcand_ext << 1);
            WIN_NEG1_A, WIN_NEG1_B: mag = -mcand_ext;
            default:                mag = '0;   // WIN_ZERO_LO / WIN_ZERO_HI
        endcase
    end

    // Each radix-4 digit weighs 4^step.
    assign pp = mag << {step, 1'b0};

endmodule

// File: rtl/booth_mult_seq.sv
// ----------------------------------------------------------------------------
// booth_mult_seq
// Sequential radix-4 Booth multiplier controller. One partial product is
// added per RUN cycle; done pulses for one cycle when the product is final.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : booth_mult_seq_if.slave (start, a, b, ready, done, product)
// Optional macro: BOOTH_SIGNED_EN -- operands and product are two's
// complement and the multiply takes WIDTH/2 steps instead of WIDTH/2+1.
// ----------------------------------------------------------------------------
module booth_mult_seq
    import booth_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    booth_mult_seq_if.slave     bus
);
    localparam int N      = booth_steps(WIDTH);
    localparam int STEP_W = (N > 1) ? $clog2(N) : 1;
    localparam int NWIN   = 2 ** STEP_W;
    localparam int XW     = 2 * WIDTH + 2;
`ifdef BOOTH_SIGNED_EN
    localparam int BEXT_W = WIDTH + 1;
`else
    localparam int BEXT_W = WIDTH + 3;
`endif
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(N - 1);

    state_e              state_reg;
    logic                ready_reg;
    logic                done_reg;
    logic [XW-1:0]       acc_reg;
    logic [XW-1:0]       acc_next;
    logic [XW-1:0]       mcand_reg;
    logic [XW-1:0]       mcand_in;
    logic [BEXT_W-1:0]   bext_reg;
    logic [BEXT_W-1:0]   bext_in;
    logic [STEP_W-1:0]   step_reg;
    logic [2*WIDTH-1:0]  product_reg;
    logic [XW-1:0]       pp;
    logic [2:0]          win_arr [NWIN];
    logic [2:0]          window;

    // Operand extension applied at capture time.
`ifdef BOOTH_SIGNED_EN
    assign mcand_in = {{(WIDTH + 2){bus.a[WIDTH-1]}}, bus.a};
    assign bext_in  = {bus.b, 1'b0};
`else
    assign mcand_in = {{(WIDTH + 2){1'b0}}, bus.a};
    assign bext_in  = {2'b00, bus.b, 1'b0};
`endif

    // One overlapping window per step; unused table slots (when N is not a
    // power of two) read as a zero digit.
    genvar gi;
    generate
        for (gi = 0; gi < NWIN; gi++) begin : g_win
            if (gi < N) begin : g_used
                assign win_arr[gi] = bext_reg[2*gi+2 -: 3];
            end else begin : g_pad
                assign win_arr[gi] = 3'b000;
            end
        end
    endgenerate

    assign window = win_arr[step_reg];

    booth_pp_gen #(
        .WIDTH  (WIDTH),
        .STEP_W (STEP_W)
    ) u_pp_gen (
        .window    (window),
        .mcand_ext (mcand_reg),
        .step      (step_reg),
        .pp        (pp)
    );

    assign acc_next = acc_reg + pp;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            ready_reg   <= 1'b1;
            done_reg    <= 1'b0;
            acc_reg     <= '0;
            mcand_reg   <= '0;
            bext_reg    <= '0;
            step_reg    <= '0;
            product_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    done_reg <= 1'b0;
                    if (bus.start) begin
                        mcand_reg   <= mcand_in;
                        bext_reg    <= bext_in;
                        acc_reg     <= '0;
                        product_reg <= '0;
                        step_reg    <= '0;
                        ready_reg   <= 1'b0;
                        state_reg   <= RUN;
                    end
                end
                RUN: begin
                    acc_reg     <= acc_next;
                    product_reg <= acc_next[2*WIDTH-1:0];
                    if (step_reg == LAST_STEP) begin
                        step_reg  <= '0;
                        done_reg  <= 1'b1;
                        state_reg <= DONE;
                    end else begin
                        step_reg <= step_reg + STEP_W'(1);
                    end
                end
                DONE: begin
                    done_reg  <= 1'b0;
                    ready_reg <= 1'b1;
                    state_reg <= IDLE;
                end
                default: begin
                    done_reg  <= 1'b0;
                    ready_reg <= 1'b1;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign bus.ready   = ready_reg;
    assign bus.done    = done_reg;
    assign bus.product = product_reg;

endmodule

// File: tb/tb_booth_mult_seq.sv
// ----------------------------------------------------------------------------
// tb_booth_mult_seq
// Self-checking bench for booth_mult_seq at WIDTH=4 (unsigned by default,
// two's complement when BOOTH_SIGNED_EN is defined).
// ----------------------------------------------------------------------------
module tb_booth_mult_seq;
    localparam int WIDTH = 4;
`ifdef BOOTH_SIGNED_EN
    localparam int N = WIDTH / 2;
`else
    localparam int N = WIDTH / 2 + 1;
`endif
    localparam int OP_WIN = N + 4;

    logic clk;
    logic rst;
    int   checks;
    int   fails;

    booth_mult_seq_if #(.WIDTH(WIDTH)) bus ();

    booth_mult_seq #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, required finish before limit");
        $fatal(1, "watchdog");
    end

    // Reference: plain integer multiply, truncated to 2*WIDTH bits.
    function automatic logic [7:0] ref_prod(input logic [3:0] x, input logic [3:0] y);
        int sx;
        int sy;
        int p;
`ifdef BOOTH_SIGNED_EN
        sx = $signed(x);
        sy = $signed(y);
`else
        sx = int'(x);
        sy = int'(y);
`endif
        p = sx * sy;
        return p[7:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one start from IDLE and watch the following OP_WIN cycles.
    // j counts cycles after the accepted start edge k (j=0 is after edge k).
    task automatic run_op(input logic [3:0] x, input logic [3:0] y,
                          input int mid_j, input logic [3:0] mx, input logic [3:0] my,
                          output int lat, output int pulses, output int rl,
                          output logic [7:0] prod_done, output logic [7:0] prod_end);
        lat       = -1;
        pulses    = 0;
        rl        = 0;
        prod_done = '0;
        bus.a     = x;
        bus.b     = y;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.a     = 4'($urandom);
        bus.b     = 4'($urandom);
        for (int j = 0; j < OP_WIN; j++) begin
            if (j == mid_j) begin
                bus.start = 1'b1;
                bus.a     = mx;
                bus.b     = my;
            end else begin
                bus.start = 1'b0;
            end
            if (!bus.ready) rl++;
            if (bus.done) begin
                pulses++;
                if (lat < 0) begin
                    lat       = j;
                    prod_done = bus.product;
                end
            end
            tick();
        end
        bus.start = 1'b0;
        prod_end  = bus.product;
        $display("op a=%0d b=%0d product=%0d latency=%0d done_pulses=%0d", x, y, prod_done, lat, pulses);
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        bus.start = 1'b1;
        bus.a     = 4'd5;
        bus.b     = 4'd5;
        tick();
        tick();
        checks++;
        if (bus.ready !== 1'b1 || bus.done !== 1'b0 || bus.product !== 8'd0) begin
            fails++;
            $display("FAIL reset_held: ready=%b done=%b product=%h, required ready=1 done=0 product=00",
                     bus.ready, bus.done, bus.product);
        end
        bus.start = 1'b0;
        rst       = 1'b0;
        tick();
        checks++;
        if (bus.ready !== 1'b1 || bus.done !== 1'b0 || bus.product !== 8'd0) begin
            fails++;
            $display("FAIL reset_release: ready=%b done=%b product=%h, required ready=1 done=0 product=00",
                     bus.ready, bus.done, bus.product);
        end
        $display("reset checked");
    endtask

    task automatic test_basic();
        int lat, pulses, rl;
        logic [7:0] pd, pe, exp_p;
        exp_p = ref_prod(4'd15, 4'd15);
        run_op(4'd15, 4'd15, -1, 4'd0, 4'd0, lat, pulses, rl, pd, pe);
        checks++;
        if (lat !== N) begin
            fails++;
            $display("FAIL basic_latency: got %0d, required %0d", lat, N);
        end
        checks++;
        if (pd !== exp_p) begin
            fails++;
            $display("FAIL basic_product: got %0d, required %0d", pd, exp_p);
        end
        checks++;
        if (rl !== N + 1) begin
            fails++;
            $display("FAIL basic_ready_low: got %0d cycles, required %0d", rl, N + 1);
        end
        checks++;
        if (pulses !== 1) begin
            fails++;
            $display("FAIL basic_done_pulses: got %0d, required 1", pulses);
        end
        checks++;
        if (pe !== exp_p) begin
            fails++;
            $display("FAIL basic_product_hold: got %0d, required %0d", pe, exp_p);
        end
    endtask

    task automatic test_patterns();
        logic [3:0] xs [3] = '{4'd7, 4'd0, 4'd13};
        logic [3:0] ys [3] = '{4'd6, 4'd13, 4'd0};
        int lat, pulses, rl;
        logic [7:0] pd, pe, exp_p;
        for (int i = 0; i < 3; i++) begin
            exp_p = ref_prod(xs[i], ys[i]);
            run_op(xs[i], ys[i], -1, 4'd0, 4'd0, lat, pulses, rl, pd, pe);
            checks++;
            if (pd !== exp_p || lat !== N) begin
                fails++;
                $display("FAIL pattern_%0d: product=%0d latency=%0d, required product=%0d latency=%0d",
                         i, pd, lat, exp_p, N);
            end
        end
    endtask

    task automatic test_start_during_run();
        int lat, pulses, rl;
        logic [7:0] pd, pe, exp_p;
        exp_p = ref_prod(4'd5, 4'd9);
        run_op(4'd5, 4'd9, 1, 4'd3, 4'd3, lat, pulses, rl, pd, pe);
        checks++;
        if (pd !== exp_p) begin
            fails++;
            $display("FAIL run_start_product: got %0d, required %0d", pd, exp_p);
        end
        checks++;
        if (pulses !== 1) begin
            fails++;
            $display("FAIL run_start_pulses: got %0d, required 1", pulses);
        end
        checks++;
        if (bus.ready !== 1'b1 || pe !== exp_p) begin
            fails++;
            $display("FAIL run_start_dropped: ready=%b product=%0d, required ready=1 product=%0d",
                     bus.ready, pe, exp_p);
        end
    endtask

    task automatic test_rst_midop();
        int lat, pulses, rl, seen;
        logic [7:0] pd, pe, exp_p;
        bus.a     = 4'd9;
        bus.b     = 4'd11;
        bus.start = 1'b1;
        tick();                 // accepted; first RUN cycle
        bus.start = 1'b0;
        tick();                 // second RUN cycle
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (bus.ready !== 1'b1 || bus.product !== 8'd0 || bus.done !== 1'b0) begin
            fails++;
            $display("FAIL rst_midop_state: ready=%b done=%b product=%0d, required ready=1 done=0 product=0",
                     bus.ready, bus.done, bus.product);
        end
        seen = 0;
        for (int j = 0; j < OP_WIN; j++) begin
            if (bus.done) seen++;
            tick();
        end
        checks++;
        if (seen !== 0) begin
            fails++;
            $display("FAIL rst_midop_no_done: got %0d pulses, required 0", seen);
        end
        $display("reset mid-operation checked");
        exp_p = ref_prod(4'd9, 4'd11);
        run_op(4'd9, 4'd11, -1, 4'd0, 4'd0, lat, pulses, rl, pd, pe);
        checks++;
        if (pd !== exp_p || lat !== N) begin
            fails++;
            $display("FAIL rst_midop_restart: product=%0d latency=%0d, required product=%0d latency=%0d",
                     pd, lat, exp_p, N);
        end
    endtask

    task automatic test_back_to_back();
        int last_done, pulses, exp_pulses, gap_bad, prod_bad, waited;
        logic [7:0] exp_p;
        exp_p      = ref_prod(4'd2, 4'd3);
        last_done  = -1;
        pulses     = 0;
        gap_bad    = 0;
        prod_bad   = 0;
        exp_pulses = 0;
        for (int j = N; j < 20; j += N + 2) exp_pulses++;
        bus.a     = 4'd2;
        bus.b     = 4'd3;
        bus.start = 1'b1;
        tick();
        for (int j = 0; j < 20; j++) begin
            if (bus.done) begin
                pulses++;
                if (bus.product !== exp_p) prod_bad++;
                if (last_done < 0) begin
                    if (j != N) gap_bad++;
                end else if (j - last_done != N + 2) begin
                    gap_bad++;
                end
                last_done = j;
                $display("b2b done at cycle %0d product=%0d", j, bus.product);
            end
            tick();
        end
        bus.start = 1'b0;
        checks++;
        if (pulses !== exp_pulses) begin
            fails++;
            $display("FAIL b2b_pulses: got %0d, required %0d", pulses, exp_pulses);
        end
        checks++;
        if (gap_bad !== 0) begin
            fails++;
            $display("FAIL b2b_spacing: %0d pulses off period, required 0 (period %0d)", gap_bad, N + 2);
        end
        checks++;
        if (prod_bad !== 0) begin
            fails++;
            $display("FAIL b2b_product: %0d wrong products, required 0 (value %0d)", prod_bad, exp_p);
        end
        waited = 0;
        while (bus.ready !== 1'b1 && waited < 20) begin
            tick();
            waited++;
        end
        tick();
        checks++;
        if (bus.ready !== 1'b1) begin
            fails++;
            $display("FAIL b2b_drain: ready=%b after %0d cycles, required 1", bus.ready, waited);
        end
    endtask

`ifdef BOOTH_SIGNED_EN
    task automatic test_signed_corners();
        int lat, pulses, rl;
        logic [7:0] pd, pe;
        run_op(4'h8, 4'h8, -1, 4'd0, 4'd0, lat, pulses, rl, pd, pe);
        checks++;
        if (pd !== 8'd64 || lat !== 2) begin
            fails++;
            $display("FAIL signed_m8_m8: product=%h latency=%0d, required product=40 latency=2", pd, lat);
        end
        run_op(4'd7, 4'h8, -1, 4'd0, 4'd0, lat, pulses, rl, pd, pe);
        checks++;
        if (pd !== 8'hC8) begin
            fails++;
            $display("FAIL signed_7_m8: product=%h, required c8", pd);
        end
    endtask
`endif

    task automatic test_exhaustive();
        int lat, pulses, rl;
        logic [7:0] pd, pe, exp_p;
        for (int x = 0; x < 16; x++) begin
            for (int y = 0; y < 16; y++) begin
                exp_p = ref_prod(4'(x), 4'(y));
                run_op(4'(x), 4'(y), -1, 4'd0, 4'd0, lat, pulses, rl, pd, pe);
                checks++;
                if (pd !== exp_p || lat !== N || pulses !== 1) begin
                    fails++;
                    $display("FAIL sweep a=%0d b=%0d: product=%0d latency=%0d pulses=%0d, required product=%0d latency=%0d pulses=1",
                             x, y, pd, lat, pulses, exp_p, N);
                end
            end
        end
    endtask

    task automatic test_random();
        int lat, pulses, rl, gap;
        logic [3:0] x, y;
        logic [7:0] pd, pe, exp_p;
        for (int i = 0; i < 40; i++) begin
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin
                bus.a = 4'($urandom);
                bus.b = 4'($urandom);
                tick();
            end
            x = 4'($urandom);
            y = 4'($urandom);
            exp_p = ref_prod(x, y);
            run_op(x, y, -1, 4'd0, 4'd0, lat, pulses, rl, pd, pe);
            checks++;
            if (pd !== exp_p || pe !== exp_p) begin
                fails++;
                $display("FAIL random_%0d a=%0d b=%0d: product=%0d held=%0d, required %0d",
                         i, x, y, pd, pe, exp_p);
            end
        end
    endtask

    initial begin
        checks    = 0;
        fails     = 0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        test_reset();
        test_basic();
        test_patterns();
        test_start_during_run();
        test_rst_midop();
        test_back_to_back();
`ifdef BOOTH_SIGNED_EN
        test_signed_corners();
`endif
        test_exhaustive();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
